// File: rtl/dmi_pkg.sv
// Shared types and register addresses for the DMI responder slice.
// Request/response structs mirror the DMI channel payloads.
package dmi_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    SUCCESS = 2'd0,
    FAILED  = 2'd2,
    BUSY    = 2'd3
  } dmi_resp_e;

  localparam logic [6:0] ADDR_DATA0  = 7'h04;
  localparam logic [6:0] ADDR_CTRL   = 7'h10;
  localparam logic [6:0] ADDR_STATUS = 7'h11;
  localparam logic [6:0] ADDR_WRCNT  = 7'h12;
  localparam logic [6:0] ADDR_EXIT   = 7'h13;

  typedef struct packed {
    logic [6:0]  addr;
    dmi_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    dmi_resp_e   resp;
    logic [31:0] data;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_regbank.sv
// Local register bank: address decode, storage, and a single commit port.
// The result is combinational; the caller latches it on the commit edge.
module dmi_regbank
  import dmi_pkg::*;
#(
  parameter int          NUM_DATA    = 4,
  parameter logic [31:0] STATUS_ID   = 32'h0000_0C82,
  parameter logic [31:0] WRCNT_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit,
  input  dmi_req_t    req,
  output dmi_resp_t   result,
  output logic [31:0] ctrl,
  output logic [31:0] exit
);

  logic [31:0]         scratch_reg [NUM_DATA];
  logic [31:0]         ctrl_reg;
  logic [31:0]         exit_reg;
  logic [31:0]         wr_count_reg;
  logic [NUM_DATA-1:0] scr_hit;
  logic                mapped;
  logic                writable;
  logic [31:0]         rd_data;
  logic                wr_ok;

  for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_scratch
    assign scr_hit[gi] = (req.addr == 7'(ADDR_DATA0 + gi));

    always_ff @(posedge clk) begin
      if (reset) begin
        scratch_reg[gi] <= '0;
      end else if (wr_ok && scr_hit[gi]) begin
        scratch_reg[gi] <= req.data;
      end
    end
  end

  always_comb begin
    rd_data  = '0;
    mapped   = 1'b0;
    writable = 1'b0;
    for (int i = 0; i < NUM_DATA; i++) begin
      if (scr_hit[i]) begin
        rd_data  = scratch_reg[i];
        mapped   = 1'b1;
        writable = 1'b1;
      end
    end
    case (req.addr)
      ADDR_CTRL: begin
        rd_data  = ctrl_reg;
        mapped   = 1'b1;
        writable = 1'b1;
      end
      ADDR_STATUS: begin
        rd_data = STATUS_ID;
        mapped  = 1'b1;
      end
      ADDR_WRCNT: begin
        rd_data = wr_count_reg;
        mapped  = 1'b1;
      end
      ADDR_EXIT: begin
        rd_data  = exit_reg;
        mapped   = 1'b1;
        writable = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    result = '{resp: FAILED, data: 32'h0};
    case (req.op)
      NOP: result.resp = SUCCESS;
      READ: begin
        if (mapped) begin
          result.resp = SUCCESS;
          result.data = rd_data;
        end
      end
      WRITE: begin
        if (writable) result.resp = SUCCESS;
      end
      default: ;
    endcase
  end

  assign wr_ok = commit && (req.op == WRITE) && writable;

  // Reads sample wr_count_reg combinationally, so they see the pre-update value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg     <= '0;
      exit_reg     <= '0;
      wr_count_reg <= WRCNT_RESET;
    end else if (wr_ok) begin
      wr_count_reg <= wr_count_reg + 32'd1;
      if (req.addr == ADDR_CTRL) ctrl_reg <= req.data;
      if (req.addr == ADDR_EXIT) exit_reg <= req.data;
    end
  end

  assign ctrl = ctrl_reg;
  assign exit = exit_reg;

endmodule

// File: rtl/dmi_responder.sv
// DMI target endpoint: accepts one request at a time, executes it against the
// local register bank after LATENCY cycles and holds the response until taken.
module dmi_responder
  import dmi_pkg::*;
#(
  parameter int          NUM_DATA    = 4,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] STATUS_ID   = 32'h0000_0C82,
  parameter logic [31:0] WRCNT_RESET = 32'h0000_0000  // power-on wr_count, for bench preloading
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        debug_req_valid,
  output logic        debug_req_ready,
  input  logic [6:0]  debug_req_bits_addr,
  input  logic [1:0]  debug_req_bits_op,
  input  logic [31:0] debug_req_bits_data,
  output logic        debug_resp_valid,
  input  logic        debug_resp_ready,
  output logic [1:0]  debug_resp_bits_resp,
  output logic [31:0] debug_resp_bits_data,
  output logic [31:0] ctrl,
  output logic [31:0] exit
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state_reg;
  logic [3:0] cnt_reg;
  dmi_req_t   req_reg;
  dmi_resp_t  resp_reg;
  dmi_req_t   req_in;
  dmi_req_t   cur_req;
  dmi_resp_t  bank_result;
  logic       accept;
  logic       commit;

  assign req_in = '{addr: debug_req_bits_addr,
                    op:   dmi_op_e'(debug_req_bits_op),
                    data: debug_req_bits_data};

  assign debug_req_ready = (state_reg == ST_IDLE) && !reset;
  assign accept          = debug_req_valid && debug_req_ready;

  // With LATENCY=1 the access happens on the accept edge itself, so the bank
  // must see the live request rather than the captured copy.
  assign cur_req = (state_reg == ST_IDLE) ? req_in : req_reg;
  assign commit  = !reset &&
                   (((state_reg == ST_IDLE) && accept && (LATENCY == 1)) ||
                    ((state_reg == ST_EXEC) && (cnt_reg == 4'd0)));

  dmi_regbank #(
    .NUM_DATA   (NUM_DATA),
    .STATUS_ID  (STATUS_ID),
    .WRCNT_RESET(WRCNT_RESET)
  ) u_regbank (
    .clk   (clk),
    .reset (reset),
    .commit(commit),
    .req   (cur_req),
    .result(bank_result),
    .ctrl  (ctrl),
    .exit  (exit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      req_reg   <= '0;
      resp_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            req_reg <= req_in;
            if (LATENCY == 1) begin
              state_reg <= ST_RESP;
            end else begin
              state_reg <= ST_EXEC;
              cnt_reg   <= 4'(LATENCY - 2);
            end
          end
        end
        ST_EXEC: begin
          if (cnt_reg == 4'd0) state_reg <= ST_RESP;
          else                 cnt_reg   <= cnt_reg - 4'd1;
        end
        ST_RESP: begin
          if (debug_resp_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (commit) resp_reg <= bank_result;
    end
  end

  assign debug_resp_valid     = (state_reg == ST_RESP);
  assign debug_resp_bits_resp = resp_reg.resp;
  assign debug_resp_bits_data = resp_reg.data;

endmodule

// File: tb/tb_dmi_responder.sv
// Directed bench for dmi_responder: a LATENCY=1 instance and a LATENCY=4
// instance with preloaded wr_count, checked against a register model scoreboard.
module tb_dmi_responder;
  import dmi_pkg::*;

  localparam logic [31:0] SID      = 32'h0000_0C82;
  localparam logic [31:0] WC1_INIT = 32'hFFFF_FFFF;
  localparam int          NUMD     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, rq_valid, rq_ready, rs_valid, rs_ready;
  logic [1:0][6:0]  rq_addr;
  logic [1:0][1:0]  rq_op, rs_resp;
  logic [1:0][31:0] rq_data, rs_data, ctrl_o, exit_o;

  dmi_responder #(.NUM_DATA(NUMD), .LATENCY(1), .STATUS_ID(SID)) dut0 (
    .clk(clk), .reset(rst[0]),
    .debug_req_valid(rq_valid[0]), .debug_req_ready(rq_ready[0]),
    .debug_req_bits_addr(rq_addr[0]), .debug_req_bits_op(rq_op[0]),
    .debug_req_bits_data(rq_data[0]),
    .debug_resp_valid(rs_valid[0]), .debug_resp_ready(rs_ready[0]),
    .debug_resp_bits_resp(rs_resp[0]), .debug_resp_bits_data(rs_data[0]),
    .ctrl(ctrl_o[0]), .exit(exit_o[0]));

  dmi_responder #(.NUM_DATA(NUMD), .LATENCY(4), .STATUS_ID(SID),
                  .WRCNT_RESET(WC1_INIT)) dut1 (
    .clk(clk), .reset(rst[1]),
    .debug_req_valid(rq_valid[1]), .debug_req_ready(rq_ready[1]),
    .debug_req_bits_addr(rq_addr[1]), .debug_req_bits_op(rq_op[1]),
    .debug_req_bits_data(rq_data[1]),
    .debug_resp_valid(rs_valid[1]), .debug_resp_ready(rs_ready[1]),
    .debug_resp_bits_resp(rs_resp[1]), .debug_resp_bits_data(rs_data[1]),
    .ctrl(ctrl_o[1]), .exit(exit_o[1]));

  typedef struct {
    int          d;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          lat[2] = '{1, 4};
  logic [31:0] m_scr [2][NUMD];
  logic [31:0] m_ctrl[2], m_exit[2], m_wc[2];
  logic [31:0] exit_before;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < NUMD; i++) m_scr[d][i] = '0;
    m_ctrl[d] = '0;
    m_exit[d] = '0;
    m_wc[d]   = (d == 1) ? WC1_INIT : 32'h0;
  endtask

  // Register-map model: computes the response and applies side effects.
  task automatic model_txn(input int d, input logic [1:0] op, input logic [6:0] a,
                           input logic [31:0] wd, output logic [1:0] er, output logic [31:0] ed);
    logic mapped, rw;
    logic [31:0] v;
    mapped = 1'b0; rw = 1'b0; v = '0;
    if (a >= 7'h04 && a < 7'(7'h04 + NUMD)) begin mapped = 1; rw = 1; v = m_scr[d][a - 7'h04]; end
    else if (a == 7'h10) begin mapped = 1; rw = 1; v = m_ctrl[d]; end
    else if (a == 7'h11) begin mapped = 1; v = SID; end
    else if (a == 7'h12) begin mapped = 1; v = m_wc[d]; end
    else if (a == 7'h13) begin mapped = 1; rw = 1; v = m_exit[d]; end
    er = 2'd2; ed = '0;
    case (op)
      2'd0: er = 2'd0;
      2'd1: if (mapped) begin er = 2'd0; ed = v; end
      2'd2: if (rw) begin
        er = 2'd0;
        m_wc[d] = m_wc[d] + 32'd1;
        if (a == 7'h10) m_ctrl[d] = wd;
        else if (a == 7'h13) m_exit[d] = wd;
        else m_scr[d][a - 7'h04] = wd;
      end
      default: ;
    endcase
  endtask

  task automatic handshake(input int d, input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    rq_valid[d] = 1'b1; rq_op[d] = op; rq_addr[d] = a; rq_data[d] = wd;
    n = 0;
    while (!rq_ready[d] && n < 50) begin @(negedge clk); n++; end
    check("req_accept", 32'(rq_ready[d]), 32'd1);
    @(posedge clk);
    #1 rq_valid[d] = 1'b0;
  endtask

  task automatic issue(input int d, input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd);
    exp_t e;
    e.d = d;
    model_txn(d, op, a, wd, e.resp, e.data);
    sb.push_back(e);
    handshake(d, op, a, wd);
  endtask

  task automatic wait_resp(input int d);
    int seen;
    seen = 1;
    exit_before = exit_o[d];
    @(negedge clk);
    while (!rs_valid[d] && seen < 40) begin
      exit_before = exit_o[d];
      @(negedge clk);
      seen++;
    end
    check($sformatf("latency d%0d", d), 32'(seen), 32'(lat[d]));
  endtask

  task automatic pop_check(input int d, output exp_t e);
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    e = '{d: d, resp: 2'd3, data: 32'hXXXX_XXXX};
    if (sb.size() > 0) e = sb.pop_front();
    check($sformatf("resp d%0d a%h", d, rq_addr[d]), 32'(rs_resp[d]), 32'(e.resp));
    check($sformatf("data d%0d a%h", d, rq_addr[d]), rs_data[d], e.data);
  endtask

  task automatic txn(input int d, input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd);
    exp_t e;
    issue(d, op, a, wd);
    wait_resp(d);
    pop_check(d, e);
    $display("txn d%0d op=%0d addr=%h wdata=%h -> resp=%0d rdata=%h", d, op, a, wd, rs_resp[d], rs_data[d]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 2'b11; rs_ready = 2'b11; rq_valid = 2'b00;
    rq_addr = '0; rq_op = '0; rq_data = '0;
    model_reset(0); model_reset(1);

    // Reset with a write offered to dut0 the whole time; it must not be taken.
    rq_valid[0] = 1'b1; rq_op[0] = WRITE; rq_addr[0] = 7'h04; rq_data[0] = 32'h55;
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(rq_ready[0]), 32'd0);
    check("rst resp_valid", 32'(rs_valid[0]), 32'd0);
    check("rst resp", 32'(rs_resp[0]), 32'd0);
    check("rst rdata", rs_data[0], 32'd0);
    check("rst ctrl", ctrl_o[0], 32'd0);
    check("rst exit", exit_o[0], 32'd0);
    rst = 2'b00; rq_valid[0] = 1'b0;
    #1 check("ready after rst", 32'(rq_ready[0]), 32'd1);

    txn(0, READ,  7'h04, 32'h0);
    txn(0, WRITE, 7'h04, 32'hDEAD_BEEF);
    txn(0, READ,  7'h04, 32'h0);
    txn(0, READ,  7'h11, 32'h0);
    txn(0, WRITE, 7'h11, 32'h1234_5678);
    txn(0, READ,  7'h11, 32'h0);
    txn(0, READ,  7'h3F, 32'h0);
    txn(0, READ,  7'h08, 32'h0);
    txn(0, RSVD,  7'h04, 32'h0BAD_0BAD);
    txn(0, READ,  7'h04, 32'h0);
    txn(0, NOP,   7'h04, 32'hFFFF_FFFF);
    txn(0, WRITE, 7'h07, 32'hA5A5_0007);
    txn(0, READ,  7'h07, 32'h0);

    // Fresh count: three writes then read wr_count.
    @(negedge clk); rst[0] = 1'b1; model_reset(0);
    @(negedge clk); rst[0] = 1'b0;
    txn(0, WRITE, 7'h05, 32'h1);
    txn(0, WRITE, 7'h06, 32'h2);
    txn(0, WRITE, 7'h10, 32'h5A);
    check("ctrl out", ctrl_o[0], m_ctrl[0]);
    txn(0, READ,  7'h12, 32'h0);
    txn(0, READ,  7'h12, 32'h0);

    // Backpressure: response held, new request ignored.
    rs_ready[0] = 1'b0;
    issue(0, READ, 7'h06, 32'h0);
    wait_resp(0);
    pop_check(0, e);
    rq_valid[0] = 1'b1; rq_op[0] = WRITE; rq_addr[0] = 7'h05; rq_data[0] = 32'h77;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold valid", 32'(rs_valid[0]), 32'd1);
      check("hold resp", 32'(rs_resp[0]), 32'(e.resp));
      check("hold data", rs_data[0], e.data);
      check("hold req_ready", 32'(rq_ready[0]), 32'd0);
    end
    $display("hold d0: response stable 5 cycles resp=%0d data=%h", rs_resp[0], rs_data[0]);
    @(negedge clk); rq_valid[0] = 1'b0; rs_ready[0] = 1'b1;
    @(posedge clk); #1;
    txn(0, READ, 7'h05, 32'h0);

    // LATENCY=4 instance: wr_count wrap from its preload.
    txn(1, READ,  7'h12, 32'h0);
    txn(1, WRITE, 7'h04, 32'h1);
    txn(1, READ,  7'h12, 32'h0);
    txn(1, READ,  7'h04, 32'h0);

    // exit updates on the commit edge, visible with the response.
    check("exit pre", exit_o[1], 32'd0);
    issue(1, WRITE, 7'h13, 32'h1);
    wait_resp(1);
    check("exit before commit", exit_before, 32'd0);
    check("exit after commit", exit_o[1], 32'd1);
    pop_check(1, e);
    $display("txn d1 write exit=1 -> resp=%0d exit=%h", rs_resp[1], exit_o[1]);
    @(posedge clk); #1;

    // Reset during EXEC of a ctrl write: dropped entirely.
    handshake(1, WRITE, 7'h10, 32'h0000_00AA);
    @(negedge clk); rst[1] = 1'b1; model_reset(1);
    @(negedge clk);
    check("exec rst ready", 32'(rq_ready[1]), 32'd0);
    check("exec rst valid", 32'(rs_valid[1]), 32'd0);
    rst[1] = 1'b0;
    #1 check("exec rst ready back", 32'(rq_ready[1]), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("dropped valid", 32'(rs_valid[1]), 32'd0);
      check("dropped ctrl", ctrl_o[1], 32'd0);
    end
    $display("reset-in-exec d1: ctrl=%h resp_valid=%0d", ctrl_o[1], rs_valid[1]);
    txn(1, READ, 7'h10, 32'h0);
    txn(1, READ, 7'h13, 32'h0);

    check("sb drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmi_responder.md
Name: dmi_responder

Overview:
- Target end of the DMI request/response channel.
- Accepts 7-bit-address DMI requests (nop/read/write) from the DTM-side initiator and executes them against a small local register bank with configurable access latency.
- Returns status/data on the response channel and exposes a control word and a simulation exit code.
- Used in simulation and FPGA benches as a stand-in debug module, so the DTM side can be exercised without the full debug module.

Parameters:
- NUM_DATA, 4, number of RW scratch registers at 0x04..0x04+NUM_DATA-1 (1..12).
- LATENCY, 1, cycles from request accept to response valid (1..15).
- STATUS_ID, 32'h0000_0C82, constant returned by the read-only status register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- debug_req_valid  in  1  request valid
- debug_req_ready  out  1  responder can accept a request
- debug_req_bits_addr  in  7  DMI register address
- debug_req_bits_op  in  2  0 nop, 1 read, 2 write, 3 reserved
- debug_req_bits_data  in  32  write data
- debug_resp_valid  out  1  response valid
- debug_resp_ready  in  1  initiator accepts response
- debug_resp_bits_resp  out  2  0 success, 2 failed
- debug_resp_bits_data  out  32  read data (0 for nop/write/failed)
- ctrl  out  32  current control register value
- exit  out  32  exit code; nonzero requests simulation end

Behaviour:
- Clocking and reset: reset is synchronous, active-high; clock is clk.
- Reset values:
  - FSM = IDLE.
  - debug_req_ready = 0 while reset is high.
  - debug_resp_valid = 0, resp = 0, resp data = 0.
  - ctrl = 0, exit = 0, all scratch registers = 0, write counter = 0.
- Register map:
  - 0x04+i: scratch[i], RW.
  - 0x10: ctrl, RW.
  - 0x11: STATUS_ID, RO.
  - 0x12: wr_count, RO, 32-bit count of successful writes, wraps 0xFFFFFFFF->0.
  - 0x13: exit, RW.
  - Any other address is unmapped.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: debug_req_ready = 1 (when not in reset).
    - On valid&ready, capture addr/op/data.
    - If LATENCY=1, go to RESP; else go to EXEC with cnt = LATENCY-2.
  - EXEC: debug_req_ready = 0. Decrement cnt; when cnt==0, go to RESP.
  - Entry to RESP (same edge):
    - Perform the access: write commits and read data is sampled.
    - Load resp/data registers and assert debug_resp_valid.
  - RESP: resp/data held stable while valid and !ready. On valid&ready, return to IDLE.
  - Latency: request handshake at edge T gives debug_resp_valid high from cycle T+LATENCY.
  - Throughput: one transaction per LATENCY+1 cycles at best; no back-to-back acceptance.
- Op semantics:
  - nop: resp 0, data 0, no state change.
  - read of a mapped address: resp 0, data = register value.
  - write to an RW address: register <= data, wr_count+1, resp 0, data 0.
  - write to an RO address (0x11, 0x12): no change, resp 2.
  - any op 3, or read/write to an unmapped address: resp 2, data 0, no change.
- A read of wr_count returns its value before any concurrent update; reads never increment it.
- ctrl and exit outputs are registered and update the cycle after the commit edge.
- Inputs on the request channel are ignored outside IDLE.
- Reset asserted in any state: immediate return to IDLE next edge. A pending response is dropped and any write not yet committed is discarded.
- Request valid asserted in the same cycle reset deasserts: not accepted, because ready is 0 during reset.

Decomposition:
- Shared package dmi_pkg:
  - dmi_op_e: NOP, READ, WRITE, RSVD.
  - dmi_resp_e: SUCCESS=0, FAILED=2, BUSY=3.
  - Address constants: ADDR_DATA0=7'h04, ADDR_CTRL=7'h10, ADDR_STATUS=7'h11, ADDR_WRCNT=7'h12, ADDR_EXIT=7'h13.
  - dmi_req_t and dmi_resp_t structs.
- One natural sub-module, dmi_regbank: decode, register storage and the commit/read port, with the FSM kept in the top.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x04, then read 0x04:
  - resp 0 for both; read data 0xDEADBEEF.
  - Response valid exactly LATENCY cycles after each accept.
- Read 0x11 -> resp 0, data STATUS_ID. Write 0x11 -> resp 2, and a subsequent read still returns STATUS_ID.
- Read 0x3F -> resp 2, data 0. Op=3 to 0x04 -> resp 2, and scratch[0] is unchanged.
- Three writes, then read 0x12 -> data 3. Preload wr_count wrap: 0xFFFFFFFF+1 -> 0.
- Hold debug_resp_ready low for 5 cycles: valid/resp/data stay stable, req_ready stays 0, and a new request offered meanwhile is not accepted.
- With LATENCY=4:
  - Write 0x13=1 -> exit=1 the cycle after the commit.
  - Assert reset during EXEC of a write to 0x10 -> ctrl stays 0, no response appears, and req_ready returns to 1 the first cycle after reset deasserts.
